// File: rtl/pcr_access_arbiter_if.sv
// Bundle of the core, host and PCR-file port signals around pcr_access_arbiter.
// The arbiter takes the slave view; the requesters plus the PCR file take the master view.
interface pcr_access_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_rw;
  logic [ADDR_W-1:0] core_req_addr;
  logic [DATA_W-1:0] core_req_data;
  logic              core_resp_valid;
  logic [DATA_W-1:0] core_resp_data;

  logic              host_req_valid;
  logic              host_req_ready;
  logic              host_req_rw;
  logic [ADDR_W-1:0] host_req_addr;
  logic [DATA_W-1:0] host_req_data;
  logic              host_resp_valid;
  logic              host_resp_ready;
  logic [DATA_W-1:0] host_resp_data;

  logic              pcr_en;
  logic              pcr_wen;
  logic [ADDR_W-1:0] pcr_addr;
  logic [DATA_W-1:0] pcr_wdata;
  logic [DATA_W-1:0] pcr_rdata;

  modport slave (
    input  core_req_valid, core_req_rw, core_req_addr, core_req_data,
    output core_req_ready, core_resp_valid, core_resp_data,
    input  host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    output host_req_ready, host_resp_valid, host_resp_data,
    output pcr_en, pcr_wen, pcr_addr, pcr_wdata,
    input  pcr_rdata
  );

  modport master (
    output core_req_valid, core_req_rw, core_req_addr, core_req_data,
    input  core_req_ready, core_resp_valid, core_resp_data,
    output host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
    input  host_req_ready, host_resp_valid, host_resp_data,
    input  pcr_en, pcr_wen, pcr_addr, pcr_wdata,
    output pcr_rdata
  );
endinterface

// File: rtl/pcr_access_arbiter.sv
// Core-priority arbiter for the single-ported PCR file, with a starvation counter
// that forces a host grant and a buffered host response path.
module pcr_access_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pcr_access_arbiter_if.slave   bus,
  output logic [1:0]            dbg_host_state,
  output logic [3:0]            dbg_starve_cnt
);

  // Handshakes: a request transfers in the cycle its valid and ready are both high;
  // ready is the combinational grant and never depends on pcr_rdata. The host
  // response holds valid and data until host_resp_ready is seen high at a clock
  // edge. The core response has no backpressure and is valid for exactly one cycle.

  localparam logic [1:0] H_IDLE = 2'd0;
  localparam logic [1:0] H_READ = 2'd1;
  localparam logic [1:0] H_RESP = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        host_state;
  logic [3:0]        starve_cnt;
  logic              core_resp_valid_q;
  logic [DATA_W-1:0] host_resp_data_q;

  logic host_elig;
  logic force_host;
  logic grant_core;
  logic grant_host;

  // Grants are suppressed while reset is held so the PCR port stays quiet.
  always_comb begin
    host_elig  = bus.host_req_valid && (host_state == H_IDLE);
    force_host = host_elig && (starve_cnt == STARVE_LIM);
    grant_host = reset && (force_host || (!bus.core_req_valid && host_elig));
    grant_core = reset && bus.core_req_valid && !force_host;
  end

  always_comb begin
    bus.pcr_en    = grant_core || grant_host;
    bus.pcr_wen   = 1'b0;
    bus.pcr_addr  = '0;
    bus.pcr_wdata = '0;
    if (grant_host) begin
      bus.pcr_wen   = bus.host_req_rw;
      bus.pcr_addr  = bus.host_req_addr;
      bus.pcr_wdata = bus.host_req_data;
    end else if (grant_core) begin
      bus.pcr_wen   = bus.core_req_rw;
      bus.pcr_addr  = bus.core_req_addr;
      bus.pcr_wdata = bus.core_req_data;
    end
  end

  assign bus.core_req_ready  = grant_core;
  assign bus.host_req_ready  = grant_host;
  assign bus.core_resp_valid = core_resp_valid_q;
  // pcr_rdata is valid the cycle after the read strobe, which is exactly the response cycle.
  assign bus.core_resp_data  = core_resp_valid_q ? bus.pcr_rdata : '0;
  assign bus.host_resp_valid = (host_state == H_RESP);
  assign bus.host_resp_data  = host_resp_data_q;

  assign dbg_host_state = host_state;
  assign dbg_starve_cnt = starve_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      host_state        <= H_IDLE;
      starve_cnt        <= '0;
      core_resp_valid_q <= 1'b0;
      host_resp_data_q  <= '0;
    end else begin
      core_resp_valid_q <= grant_core && !bus.core_req_rw;

      if (grant_host || !host_elig) begin
        starve_cnt <= '0;
      end else if (grant_core && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      case (host_state)
        H_IDLE: begin
          if (grant_host) begin
            if (bus.host_req_rw) begin
              host_state       <= H_RESP;
              host_resp_data_q <= '0;
            end else begin
              host_state <= H_READ;
            end
          end
        end
        H_READ: begin
          host_resp_data_q <= bus.pcr_rdata;
          host_state       <= H_RESP;
        end
        H_RESP: begin
          if (bus.host_resp_ready) begin
            host_state <= H_IDLE;
          end
        end
        default: host_state <= H_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcr_access_arbiter.sv
// Directed bench for pcr_access_arbiter: a behavioural PCR file plus
// hand-computed expectations checked with immediate assertions.
module tb_pcr_access_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_host_state;
  logic [3:0] dbg_starve_cnt;
  int         checks;
  int         errors;

  logic [DATA_W-1:0] pcr_mem [32];

  pcr_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pcr_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_host_state (dbg_host_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PCR file: synchronous write, registered read one cycle later.
  always @(posedge clk) begin
    if (bus.pcr_en && bus.pcr_wen) pcr_mem[bus.pcr_addr] <= bus.pcr_wdata;
    if (bus.pcr_en && !bus.pcr_wen) bus.pcr_rdata <= pcr_mem[bus.pcr_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic core_drive(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    bus.core_req_valid = v;
    bus.core_req_rw    = rw;
    bus.core_req_addr  = a;
    bus.core_req_data  = d;
  endtask

  task automatic host_drive(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    bus.host_req_valid = v;
    bus.host_req_rw    = rw;
    bus.host_req_addr  = a;
    bus.host_req_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) pcr_mem[i] = 64'(i) * 64'h0101;
    pcr_mem[3] = 64'h55;
    pcr_mem[1] = 64'h1234;
    bus.pcr_rdata = '0;
    reset = 1'b0;
    core_drive(0, 0, 0, 0);
    host_drive(0, 0, 0, 0);
    bus.host_resp_ready = 1'b0;
    repeat (2) tick();
    settle();
    chk("rst_core_resp_valid", 64'(bus.core_resp_valid), 0);
    chk("rst_host_resp_valid", 64'(bus.host_resp_valid), 0);
    chk("rst_pcr_en", 64'(bus.pcr_en), 0);
    chk("rst_host_resp_data", bus.host_resp_data, 0);
    chk("rst_state", 64'(dbg_host_state), 0);
    chk("rst_starve", 64'(dbg_starve_cnt), 0);
    tick();
    reset = 1'b1;

    // Core read of addr 3
    tick();
    core_drive(1, 0, 3, 0);
    settle();
    chk("cr_pcr_en", 64'(bus.pcr_en), 1);
    chk("cr_pcr_wen", 64'(bus.pcr_wen), 0);
    chk("cr_pcr_addr", 64'(bus.pcr_addr), 3);
    chk("cr_core_ready", 64'(bus.core_req_ready), 1);
    chk("cr_host_ready", 64'(bus.host_req_ready), 0);
    tick();
    core_drive(0, 0, 0, 0);
    settle();
    chk("cr_resp_valid", 64'(bus.core_resp_valid), 1);
    chk("cr_resp_data", bus.core_resp_data, 64'h55);
    chk("cr_idle_pcr_en", 64'(bus.pcr_en), 0);

    // Host write of addr 7, response data 0, held until ready
    tick();
    host_drive(1, 1, 7, 64'hDEAD_BEEF);
    settle();
    chk("hw_host_ready", 64'(bus.host_req_ready), 1);
    chk("hw_pcr_wen", 64'(bus.pcr_wen), 1);
    chk("hw_pcr_addr", 64'(bus.pcr_addr), 7);
    chk("hw_pcr_wdata", bus.pcr_wdata, 64'hDEAD_BEEF);
    tick();
    host_drive(0, 0, 0, 0);
    settle();
    chk("hw_resp_valid", 64'(bus.host_resp_valid), 1);
    chk("hw_resp_data", bus.host_resp_data, 0);
    tick();
    bus.host_resp_ready = 1'b1;
    settle();
    chk("hw_resp_valid_hold", 64'(bus.host_resp_valid), 1);
    tick();
    bus.host_resp_ready = 1'b0;
    settle();
    chk("hw_resp_cleared", 64'(bus.host_resp_valid), 0);
    chk("hw_mem7", pcr_mem[7], 64'hDEAD_BEEF);

    // Starvation: core valid continuously, host read pending from cycle 0
    tick();
    core_drive(1, 0, 0, 0);
    host_drive(1, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("st_core_ready_c%0d", c), 64'(bus.core_req_ready), 1);
      chk($sformatf("st_host_ready_c%0d", c), 64'(bus.host_req_ready), 0);
      chk($sformatf("st_cnt_c%0d", c), 64'(dbg_starve_cnt), 64'(c));
      tick();
    end
    settle();
    chk("st_host_forced", 64'(bus.host_req_ready), 1);
    chk("st_core_blocked", 64'(bus.core_req_ready), 0);
    chk("st_pcr_addr", 64'(bus.pcr_addr), 1);
    tick();
    host_drive(0, 0, 0, 0);
    settle();
    chk("st_core_again", 64'(bus.core_req_ready), 1);
    chk("st_cnt_cleared", 64'(dbg_starve_cnt), 0);
    tick();
    core_drive(0, 0, 0, 0);
    settle();
    chk("st_host_resp_valid", 64'(bus.host_resp_valid), 1);
    chk("st_host_resp_data", bus.host_resp_data, 64'h1234);
    tick();
    bus.host_resp_ready = 1'b1;
    tick();
    bus.host_resp_ready = 1'b0;

    // Host read with response backpressure for 5 cycles
    host_drive(1, 0, 1, 0);
    settle();
    chk("bp_host_ready", 64'(bus.host_req_ready), 1);
    tick();
    settle();
    chk("bp_read_state", 64'(dbg_host_state), 1);
    chk("bp_no_regrant_read", 64'(bus.host_req_ready), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      settle();
      chk($sformatf("bp_valid_c%0d", c), 64'(bus.host_resp_valid), 1);
      chk($sformatf("bp_data_c%0d", c), bus.host_resp_data, 64'h1234);
      chk($sformatf("bp_no_grant_c%0d", c), 64'(bus.host_req_ready), 0);
    end
    tick();
    bus.host_resp_ready = 1'b1;
    settle();
    chk("bp_no_grant_on_ready", 64'(bus.host_req_ready), 0);
    tick();
    bus.host_resp_ready = 1'b0;
    settle();
    chk("bp_grant_after_ready", 64'(bus.host_req_ready), 1);
    tick();
    host_drive(0, 0, 0, 0);
    tick();
    settle();
    chk("rs_in_resp", 64'(bus.host_resp_valid), 1);

    // Reset while in H_RESP drops the response
    tick();
    reset = 1'b0;
    core_drive(1, 0, 3, 0);
    settle();
    chk("rs_pcr_en_low", 64'(bus.pcr_en), 0);
    tick();
    settle();
    chk("rs_resp_dropped", 64'(bus.host_resp_valid), 0);
    chk("rs_state", 64'(dbg_host_state), 0);
    chk("rs_starve", 64'(dbg_starve_cnt), 0);
    chk("rs_pcr_en", 64'(bus.pcr_en), 0);
    chk("rs_core_resp", 64'(bus.core_resp_valid), 0);
    tick();
    reset = 1'b1;
    core_drive(0, 0, 0, 0);
    host_drive(1, 1, 4, 64'hABC);
    settle();
    chk("rs_host_grant", 64'(bus.host_req_ready), 1);
    chk("rs_host_wen", 64'(bus.pcr_wen), 1);
    tick();
    host_drive(0, 0, 0, 0);
    settle();
    chk("rs_host_resp", 64'(bus.host_resp_valid), 1);
    chk("rs_host_resp_data", bus.host_resp_data, 0);
    tick();
    bus.host_resp_ready = 1'b1;
    tick();
    bus.host_resp_ready = 1'b0;

    // Core write then read of addr 2, then back-to-back reads
    core_drive(1, 1, 2, 64'hFF);
    settle();
    chk("wr_core_ready", 64'(bus.core_req_ready), 1);
    chk("wr_pcr_wen", 64'(bus.pcr_wen), 1);
    tick();
    core_drive(1, 0, 2, 0);
    settle();
    chk("wr_no_resp", 64'(bus.core_resp_valid), 0);
    chk("rd_pcr_wen", 64'(bus.pcr_wen), 0);
    tick();
    core_drive(1, 0, 3, 0);
    settle();
    chk("wr_rd_valid", 64'(bus.core_resp_valid), 1);
    chk("wr_rd_data", bus.core_resp_data, 64'hFF);
    tick();
    core_drive(1, 0, 1, 0);
    settle();
    chk("b2b_valid0", 64'(bus.core_resp_valid), 1);
    chk("b2b_data0", bus.core_resp_data, 64'h55);
    tick();
    core_drive(0, 0, 0, 0);
    settle();
    chk("b2b_valid1", 64'(bus.core_resp_valid), 1);
    chk("b2b_data1", bus.core_resp_data, 64'h1234);
    tick();
    settle();
    chk("b2b_done", 64'(bus.core_resp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcr_access_arbiter.md
Name: pcr_access_arbiter

Overview:
- Arbitrates a single-ported 32-entry × 64-bit processor control register (PCR) file between two requesters: the core CSR pipeline and the host (debug/HTIF) interface.
- Sits between both requesters and the PCR file. Drives the file's one read/write port and returns read data to whichever requester was granted.
- Core has priority. A starvation counter guarantees the host makes forward progress.
- The host response path is buffered with a valid/ready handshake.

Parameters:
ADDR_W, 5, PCR address width (32 registers)
DATA_W, 64, PCR data width
STARVE_MAX, 4, consecutive host-lost arbitration cycles before host is forced to win (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
core_req_valid  in  1  core request present
core_req_ready  out  1  core request accepted this cycle
core_req_rw  in  1  1=write, 0=read
core_req_addr  in  ADDR_W  core PCR address
core_req_data  in  DATA_W  core write data
core_resp_valid  out  1  core read data valid (no backpressure)
core_resp_data  out  DATA_W  core read data
host_req_valid  in  1  host request present
host_req_ready  out  1  host request accepted this cycle
host_req_rw  in  1  1=write, 0=read
host_req_addr  in  ADDR_W  host PCR address
host_req_data  in  DATA_W  host write data
host_resp_valid  out  1  host response valid (held until accepted)
host_resp_ready  in  1  host consumes response
host_resp_data  out  DATA_W  host read data (0 for writes)
pcr_en  out  1  PCR port access this cycle
pcr_wen  out  1  PCR write strobe
pcr_addr  out  ADDR_W  PCR address
pcr_wdata  out  DATA_W  PCR write data
pcr_rdata  in  DATA_W  PCR read data, valid the cycle after pcr_en with pcr_wen=0

Behaviour:
- Reset (reset==0 at clk edge):
  - All outputs are 0: resp valids, readys, pcr_en, pcr_wen, data registers.
  - Starvation counter cleared to 0; host FSM to H_IDLE.
  - An in-flight response is dropped.
- Host FSM:
  - H_IDLE: host is eligible for grant.
  - H_READ: entered on a host read grant; lasts 1 cycle. Captures pcr_rdata into the host response register. Sets host_resp_valid; goes to H_RESP.
  - A host write grant goes directly to H_RESP with response data 0.
  - H_RESP: host_resp_valid=1 and host_resp_data is stable. On host_resp_ready=1 → H_IDLE.
  - The host is not eligible for grant outside H_IDLE.
- Arbitration, evaluated combinationally each cycle:
  - host_elig = host_req_valid & (FSM==H_IDLE).
  - force_host = host_elig & (starve_cnt == STARVE_MAX).
  - If force_host: grant host.
  - Else if core_req_valid: grant core.
  - Else if host_elig: grant host.
  - Else: no grant.
- Ready signals equal the grant; at most one ready is high per cycle.
- Grant drives pcr_en=1, pcr_wen=rw, pcr_addr, pcr_wdata from the granted requester in the same cycle.
- Starvation counter:
  - Increments when host_elig=1 and the core is granted.
  - Clears on any host grant or when host_elig=0.
  - Saturates at STARVE_MAX.
- Core response:
  - A core read grant in cycle N gives core_resp_valid=1 in cycle N+1, with core_resp_data = pcr_rdata.
  - Core writes produce no response.
  - Back-to-back core reads give one response per cycle.
- Write then read of the same address on consecutive grants returns the new value; the PCR file provides write-before-read ordering.
- No combinational path from pcr_rdata to any request ready.
- Reset mid-operation takes effect immediately. An H_RESP response is lost and the host must reissue.

Test Plan:
- Core read addr 3 only (PCR[3]=0x55) → pcr_en=1, pcr_wen=0, addr=3 in cycle N; core_resp_valid=1, data=0x55 in N+1; host ready stays 0.
- Host write addr 7 data 0xDEAD_BEEF, core idle → pcr_wen=1, addr 7, wdata 0xDEADBEEF; host_resp_valid=1 next cycle with data 0; cleared when host_resp_ready=1.
- Core valid continuously, host read valid from cycle 0, STARVE_MAX=4 → core granted cycles 0–3; host granted cycle 4; core_req_ready=0 in cycle 4; core granted again cycle 5.
- Host read addr 1 (PCR[1]=0x1234), host_resp_ready held 0 for 5 cycles → host_resp_valid/data held at 0x1234; new host request not granted until the cycle after ready=1.
- Reset=0 asserted while in H_RESP → next cycle host_resp_valid=0, starve_cnt=0, pcr_en=0; after reset=1, host request granted normally.
- Core write addr 2 data 0xFF, then core read addr 2 next cycle → core_resp_data=0xFF.
